stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
Shares one valid/ready stream channel among NumIn requesters using round-robin arbitration. Each input follows the same handshake as stream_register. The winning beat is captured in a one-entry output register, so the output is fully registered, has 1-cycle latency and sustains 1 beat/cycle. It sits in front of stream_register / register_skid_buffer stages wherever several producers feed one consumer.

Parameters:
NumIn, 4, number of requesters; legal range is 2 or more.
DW, 8, data width per requester.
IdxW, $clog2(NumIn), width of the source index; derived, do not override.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous flush of output register and arbitration pointer
valid_i  in  NumIn  per-requester valid
ready_o  out  NumIn  per-requester ready
data_i  in  NumIn*DW  packed requester data; requester k occupies bits [k*DW +: DW]
valid_o  out  1  output valid (registered)
ready_i  in  1  downstream ready
data_o  out  DW  output data (registered)
idx_o  out  IdxW  source index of the beat on data_o (registered)

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
  - Values in reset: valid_o=0, data_o=0, idx_o=0, pointer ptr=0.
  - ready_o is forced to all-0 while rst_ni=0.
- Output stage:
  - It can accept a beat when empty or draining: acc = ~valid_o | ready_i.
- Grant (combinational):
  - gnt is one-hot: the first k with valid_i[k]=1, searching ptr, ptr+1, … NumIn-1, 0, … ptr-1 (wrap-around).
  - gnt is all-0 if no valid_i is set.
  - ready_o[k] = gnt[k] & acc. At most one ready_o bit is high.
- Handshake on input k: valid_i[k] & ready_o[k]. On the next edge:
  - valid_o=1, data_o=data_i[k], idx_o=k.
  - ptr = k+1 (mod NumIn; NumIn-1 wraps to 0).
- No handshake and ready_i=1: valid_o←0 on the next edge. data_o and idx_o hold their values (don't-care).
- Stall (valid_o=1, ready_i=0):
  - valid_o, data_o and idx_o hold stable.
  - All ready_o=0.
  - ptr holds.
- Arbitration never depends on ready_i in a way that drops a beat. An unaccepted requester keeps valid_i high. Preemption by another requester before acceptance is legal, since no input handshake occurred.
- Simultaneous drain and fill (valid_o=1, ready_i=1, new grant): the new beat replaces the old one in the same edge, with no bubble.
- ptr advances only on an input handshake. It is never affected by requesters that are not valid.
- Latency: input handshake to valid_o is 1 cycle. Throughput is 1 beat/cycle.
- Starvation bound: a requester held valid is granted within NumIn accepted beats.
- clear_i=1 (synchronous, priority over handshake):
  - Next edge: valid_o=0, ptr=0.
  - ready_o is forced to all-0 during the clear cycle, so no input beat is consumed.
  - Any pending output beat is discarded.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight beat is lost.
- Inputs with valid_i=0 have don't-care data_i.

Optional Feature:
Macro STREAM_RR_ARB_ASSERT_EN.
- Defined: the RTL includes SVA checks, reported with $error and disabled while rst_ni=0:
  - $onehot0(ready_o).
  - valid_o, data_o and idx_o are stable while valid_o & ~ready_i.
  - For every k, valid_i[k] stays high until ready_o[k] (input protocol).
  - ptr < NumIn.
- Not defined: no assertion code is compiled; functional behaviour is identical.

Test Plan:
1. Reset: hold rst_ni=0 with all valid_i=1 -> ready_o=0000, valid_o=0, data_o=0x00, idx_o=0. Release -> first grant goes to input 0.
2. All 4 valid, data_i[k]=0x10+k, ready_i=1 constant -> valid_o=1 from cycle 2 onward. idx_o sequence is 0,1,2,3,0,1…; data_o sequence is 0x10,0x11,0x12,0x13,0x10…; one beat/cycle, no bubbles.
3. Only input 2 valid, ready_i=1 -> ready_o=0100 every cycle; back-to-back beats with idx_o=2. ptr alternates 3 after each beat, and the search wraps back to 2.
4. Inputs 1 and 3 valid, ready_i=0 for 5 cycles after the first beat:
   - While stalled: valid_o=1, data_o and idx_o=1 are stable, ready_o=0000.
   - After ready_i=1: next idx_o=3, then 1.
5. clear_i pulsed while valid_o=1 and ready_i=0:
   - Next cycle: valid_o=0.
   - ready_o=0000 during the clear cycle.
   - With inputs 2 and 3 valid afterwards, the next grant goes to input 2 (ptr=0 search).
6. rst_ni asserted mid-stream with valid_o=1 -> valid_o drops to 0 immediately (asynchronously). After release, arbitration restarts from input 0.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among NumIn requesters, fully registered output.
// Optional SVA protocol checks are compiled in when STREAM_RR_ARB_ASSERT_EN is defined.
module stream_rr_arbiter #(
    parameter int unsigned NumIn = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned IdxW  = $clog2(NumIn)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [NumIn-1:0]    valid_i,
    output logic [NumIn-1:0]    ready_o,
    input  logic [NumIn*DW-1:0] data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DW-1:0]       data_o,
    output logic [IdxW-1:0]     idx_o
);

    logic            valid_q;
    logic [DW-1:0]   data_q;
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] ptr_q;

    logic [NumIn-1:0] gnt;
    logic [IdxW-1:0]  sel_idx;
    logic [DW-1:0]    sel_data;
    logic             found;
    logic             acc;
    logic             hs;
    int unsigned      k;

    // Search ptr, ptr+1, ... with wrap-around; the first valid requester wins.
    always_comb begin
        gnt      = '0;
        sel_idx  = '0;
        sel_data = '0;
        found    = 1'b0;
        k        = 0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            k = (32'(ptr_q) + i) % NumIn;
            if (!found && valid_i[k]) begin
                found    = 1'b1;
                gnt[k]   = 1'b1;
                sel_idx  = IdxW'(k);
                sel_data = data_i[k*DW +: DW];
            end
        end
    end

    assign acc     = ~valid_q | ready_i;
    assign ready_o = (rst_ni && !clear_i && acc) ? gnt : '0;
    assign hs      = |(valid_i & ready_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (hs) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            idx_q   <= sel_idx;
            ptr_q   <= (sel_idx == IdxW'(NumIn - 1)) ? '0 : sel_idx + IdxW'(1);
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

`ifdef STREAM_RR_ARB_ASSERT_EN
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(ready_o))
        else $error("ready_o not one-hot");

    // A clear legitimately discards a stalled beat, so it is excluded here.
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_q && !ready_i && !clear_i) |=> (valid_q && $stable(data_q) && $stable(idx_q)))
        else $error("output changed during stall");

    a_ptr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(ptr_q) < NumIn)
        else $error("ptr out of range");

    for (genvar g = 0; g < NumIn; g++) begin : g_in_proto
        a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_i[g] && !ready_o[g]) |=> valid_i[g])
            else $error("valid_i dropped before ready_o");
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (NumIn=4, DW=8).
module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [3:0]  valid_i;
    logic [3:0]  ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  data_o;
    logic [1:0]  idx_o;

    int errors = 0;
    int checks = 0;
    int exp_idx;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NumIn(4), .DW(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .idx_o   (idx_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input int idx);
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".idx"},   32'(idx_o),   32'(idx));
        chk({tag, ".data"},  32'(data_o),  32'(8'h10 + idx));
    endtask

    initial begin
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        valid_i = 4'b1111;
        data_i  = 32'h1312_1110;
        ready_i = 1'b1;

        // 1. reset with all requesters valid
        tick();
        tick();
        chk("rst.ready", 32'(ready_o), 32'h0);
        chk("rst.valid", 32'(valid_o), 32'h0);
        chk("rst.data",  32'(data_o),  32'h0);
        chk("rst.idx",   32'(idx_o),   32'h0);
        rst_ni = 1'b1;
        #1;
        chk("rel.ready", 32'(ready_o), 32'b0001);

        // 2. all valid, ready_i high: strict rotation, no bubbles
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_idx = i % 4;
            chk_out("rot", 1'b1, exp_idx);
            chk("rot.ready", 32'(ready_o), 32'(1 << ((exp_idx + 1) % 4)));
        end

        // 3. only input 2 valid: back-to-back beats through the wrap
        valid_i = 4'b0100;
        #1;
        chk("solo.ready0", 32'(ready_o), 32'b0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("solo", 1'b1, 2);
            chk("solo.ready", 32'(ready_o), 32'b0100);
        end

        // clear with nothing pending to bring ptr back to 0
        valid_i = 4'b0000;
        clear_i = 1'b1;
        #1;
        chk("clr0.ready", 32'(ready_o), 32'h0);
        tick();
        clear_i = 1'b0;
        chk("clr0.valid", 32'(valid_o), 32'h0);

        // 4. inputs 1 and 3, stall 5 cycles after the first beat
        valid_i = 4'b1010;
        ready_i = 1'b0;
        #1;
        chk("stall.ready0", 32'(ready_o), 32'b0010);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_out("stall", 1'b1, 1);
            chk("stall.ready", 32'(ready_o), 32'h0);
            tick();
        end
        ready_i = 1'b1;
        #1;
        chk("unstall.ready", 32'(ready_o), 32'b1000);
        tick();
        chk_out("unstall.a", 1'b1, 3);
        tick();
        chk_out("unstall.b", 1'b1, 1);

        // 5. clear while a beat is stalled on the output
        ready_i = 1'b0;
        valid_i = 4'b1100;
        clear_i = 1'b1;
        #1;
        chk("clr.ready", 32'(ready_o), 32'h0);
        tick();
        clear_i = 1'b0;
        chk("clr.valid", 32'(valid_o), 32'h0);
        #1;
        chk("clr.ready_after", 32'(ready_o), 32'b0100);
        ready_i = 1'b1;
        tick();
        chk_out("clr.grant", 1'b1, 2);

        // 6. asynchronous reset mid-stream
        valid_i = 4'b1111;
        tick();
        chk_out("pre_rst", 1'b1, 3);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst.valid", 32'(valid_o), 32'h0);
        chk("arst.idx",   32'(idx_o),   32'h0);
        chk("arst.data",  32'(data_o),  32'h0);
        chk("arst.ready", 32'(ready_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("arst.rel_ready", 32'(ready_o), 32'b0001);
        tick();
        chk_out("arst.first", 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
